// File: rtl/sprite_frame_scheduler_pkg.sv
// Shared types and constants for the sprite frame scheduler.
package sprite_frame_scheduler_pkg;

  localparam int FRAME_W    = 320;
  localparam int FRAME_H    = 240;
  localparam int SPRITE_DIM = 8;
  localparam int COORD_W    = 17;
  localparam int IMG_W      = 8;

  // Largest top-left address that keeps the whole 8x8 sprite on screen:
  // x <= 312 and y <= 232, i.e. 312 + 320*232 = 74552.
  localparam int MAX_COORD  = (FRAME_H - SPRITE_DIM) * FRAME_W + (FRAME_W - SPRITE_DIM);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } sched_state_e;

  // One table entry: 1 + 17 + 8 = 26 bits.
  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] coord;
    logic [IMG_W-1:0]   img;
  } sprite_entry_t;

  // True when a sprite at this top-left address fits inside the frame.
  function automatic logic coord_in_frame(input logic [COORD_W-1:0] c);
    return c <= COORD_W'(MAX_COORD);
  endfunction

endpackage

// File: rtl/sprite_frame_scheduler_if.sv
// Draw-engine handshake: scheduler is the master, engine the slave.
interface sprite_frame_scheduler_if;
  import sprite_frame_scheduler_pkg::*;

  logic               draw_start;
  logic [COORD_W-1:0] draw_coord;
  logic [IMG_W-1:0]   draw_img;
  logic               draw_rdy;

  modport master (output draw_start, draw_coord, draw_img, input draw_rdy);
  modport slave  (input draw_start, draw_coord, draw_img, output draw_rdy);

endinterface

// File: rtl/sprite_frame_scheduler_sprite_table.sv
// Sprite descriptor register file: synchronous write, async read, cleared on reset.
module sprite_table
  import sprite_frame_scheduler_pkg::*;
#(
  parameter  int NUM_SPRITES = 16,
  localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IDX_W-1:0] widx,
  input  sprite_entry_t wdata,
  input  logic [IDX_W-1:0] ridx,
  output sprite_entry_t rdata
);

  sprite_entry_t mem_q [NUM_SPRITES];
  sprite_entry_t mem_d [NUM_SPRITES];

  // Next table contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end

  // Table storage; reset clears every entry (en=0, coord=0, img=0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read sees the pre-edge value, so a same-cycle write to the scanned
  // entry only takes effect on a later scan.
  assign rdata = mem_q[ridx];

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Per-frame sequencer: walks the sprite table once per frame_start and
// issues one engine draw per enabled, in-frame entry.
module sprite_frame_scheduler
  import sprite_frame_scheduler_pkg::*;
#(
  parameter  int NUM_SPRITES = 16,
  localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    tbl_we,
  input  logic [IDX_W-1:0]        tbl_idx,
  input  logic [COORD_W-1:0]      tbl_coord,
  input  logic [IMG_W-1:0]        tbl_img,
  input  logic                    tbl_en,
  sprite_frame_scheduler_if.master draw,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_overrun,
  output logic [IDX_W:0]          drawn_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     run_cnt_q, run_cnt_d;
  logic [IDX_W:0]     drawn_cnt_q, drawn_cnt_d;
  logic               draw_start_q, draw_start_d;
  logic [COORD_W-1:0] draw_coord_q, draw_coord_d;
  logic [IMG_W-1:0]   draw_img_q, draw_img_d;

  sprite_entry_t      wr_entry, rd_entry;

  assign wr_entry = '{en: tbl_en, coord: tbl_coord, img: tbl_img};

  sprite_table #(.NUM_SPRITES(NUM_SPRITES)) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .widx  (tbl_idx),
    .wdata (wr_entry),
    .ridx  (idx_q),
    .rdata (rd_entry)
  );

  // Next-state logic for the frame pass.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_cnt_d    = run_cnt_q;
    drawn_cnt_d  = drawn_cnt_q;
    draw_start_d = 1'b0;
    draw_coord_d = draw_coord_q;
    draw_img_d   = draw_img_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = SCAN;
          idx_d     = '0;
          run_cnt_d = '0;
        end
      end
      SCAN: begin
        if (rd_entry.en && coord_in_frame(rd_entry.coord)) begin
          draw_coord_d = rd_entry.coord;
          draw_img_d   = rd_entry.img;
          state_d      = ISSUE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ISSUE: begin
        // Start goes out on the registered output, so the engine sees it
        // while we sit in WAIT_ACK.
        if (draw.draw_rdy) begin
          draw_start_d = 1'b1;
          state_d      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Engine drops rdy during this cycle; its rdy is not trusted yet.
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (draw.draw_rdy) begin
          run_cnt_d = run_cnt_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        drawn_cnt_d = run_cnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers; async reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      run_cnt_q    <= '0;
      drawn_cnt_q  <= '0;
      draw_start_q <= 1'b0;
      draw_coord_q <= '0;
      draw_img_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_cnt_q    <= run_cnt_d;
      drawn_cnt_q  <= drawn_cnt_d;
      draw_start_q <= draw_start_d;
      draw_coord_q <= draw_coord_d;
      draw_img_q   <= draw_img_d;
    end
  end

  assign draw.draw_start = draw_start_q;
  assign draw.draw_coord = draw_coord_q;
  assign draw.draw_img   = draw_img_q;
  assign drawn_cnt       = drawn_cnt_q;
  assign busy            = (state_q != IDLE);
  assign frame_done      = (state_q == DONE);
  // Flagged in the same cycle as the ignored pulse, including during DONE.
  assign frame_overrun   = frame_start && (state_q != IDLE);

endmodule
